div_arbiter: RTL and testbench

//  Shares one unsigned 32-bit sequential divider (div) between N_REQ requesters.

---
 rtl/div_pkg.sv | 10 +
 rtl/div_arbiter_if.sv | 29 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/div_arbiter.sv | 115 +++++++++++
 tb/tb_div_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider arbiter slice.
package div_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam int DIV_LATENCY = 64;
  // Sliced down to the operand width by users; operand widths up to 64 supported.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_arbiter_if.sv
// Requester/response bundle between the issue ports and the divider arbiter.
interface div_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_dividend;
  logic [N_REQ*WIDTH-1:0] req_divisor;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_quotient;
  logic [WIDTH-1:0]       rsp_remainder;
  logic                   rsp_dbz;
  logic                   rsp_timeout;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW:0] pos;
  logic        found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!found && req[pos[IW-1:0]]) begin
        found              = 1'b1;
        grant[pos[IW-1:0]] = 1'b1;
        idx                = pos[IW-1:0];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider among N_REQ requesters, one op in flight,
// with local divide-by-zero answers and a watchdog on the divider handshake.
module div_arbiter
  import div_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  div_arbiter_if.slave     bus,
  output logic             busy,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W = $clog2(MAX_CYCLES + 1);

  state_t           state, state_nx;
  logic [ID_W-1:0]  rr_ptr, g_idx, id_r;
  logic [N_REQ-1:0] g_onehot;
  logic             any_req;
  logic [WIDTH-1:0] sel_dividend, sel_divisor, quo_r, rem_r;
  logic             dbz_r, to_r;
  logic [WD_W-1:0]  wd;
  logic             wd_expired;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (g_onehot),
    .idx   (g_idx),
    .any   (any_req)
  );

  assign sel_dividend = bus.req_dividend[int'(g_idx)*WIDTH +: WIDTH];
  assign sel_divisor  = bus.req_divisor[int'(g_idx)*WIDTH +: WIDTH];
  assign wd_expired   = (wd == WD_W'(MAX_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = (sel_divisor == '0) ? RESP : LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (div_done || wd_expired) state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant is visible only while idle, so at most one op is accepted per cycle.
  assign bus.req_ready     = (state == IDLE) ? g_onehot : '0;
  assign bus.rsp_valid     = (state == RESP);
  assign bus.rsp_id        = id_r;
  assign bus.rsp_quotient  = quo_r;
  assign bus.rsp_remainder = rem_r;
  assign bus.rsp_dbz       = dbz_r;
  assign bus.rsp_timeout   = to_r;
  assign busy              = (state != IDLE);
  assign div_start         = (state == LAUNCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      id_r         <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      quo_r        <= '0;
      rem_r        <= '0;
      dbz_r        <= 1'b0;
      to_r         <= 1'b0;
      wd           <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          id_r         <= g_idx;
          rr_ptr       <= (g_idx == ID_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
          div_dividend <= sel_dividend;
          div_divisor  <= sel_divisor;
          dbz_r        <= (sel_divisor == '0);
          to_r         <= 1'b0;
          if (sel_divisor == '0) begin
            quo_r <= DBZ_QUOTIENT[WIDTH-1:0];
            rem_r <= sel_dividend;
          end
        end
        LAUNCH: wd <= '0;
        WAIT: begin
          if (div_done) begin
            quo_r <= div_quotient;
            rem_r <= div_remainder;
          end else if (wd_expired) begin
            to_r  <= 1'b1;
            quo_r <= '0;
            rem_r <= '0;
          end else if (wd != '1) begin
            wd <= wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized bench for div_arbiter with a behavioural divider and reference model.
module tb_div_arbiter;
  import div_pkg::*;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int MAXC = 100;

  typedef struct {
    int           id;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  logic         busy, div_start;
  logic [W-1:0] div_dividend, div_divisor;
  logic         div_done = 1'b0;
  logic [W-1:0] div_quotient = '0, div_remainder = '0;

  div_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_CYCLES(MAXC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .busy          (busy),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  // Divider stand-in: no reset, restarts on start, done DIV_LATENCY+1 edges after start is sampled.
  int           dcnt = 0;
  int           start_cnt = 0;
  bit           hang = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '1;

  always @(posedge clk) begin
    div_done <= 1'b0;
    if (div_start) begin
      dcnt      <= DIV_LATENCY;
      op_a      <= div_dividend;
      op_b      <= div_divisor;
      start_cnt <= start_cnt + 1;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1 && !hang) begin
        div_done      <= 1'b1;
        div_quotient  <= op_a / op_b;
        div_remainder <= op_a % op_b;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int model_ptr = 0;

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic exp_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.id  = id;
    e.dbz = (b == 0);
    e.q   = (b == 0) ? '1 : a / b;
    e.r   = (b == 0) ? a : a % b;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_divisor();
    if ($urandom_range(0, 5) == 0) return '0;
    return $urandom >> $urandom_range(0, 31);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid[id]              = 1'b1;
    bus.req_dividend[id*W +: W]    = a;
    bus.req_divisor[id*W +: W]     = b;
  endtask

  task automatic wait_rsp(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (bus.rsp_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (div_start !== 1'b0) begin n_err++; $display("FAIL reset_div_start got %b want 0", div_start); end
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready); end
    n_cmp++; if ({bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout} !== '0) begin
      n_err++; $display("FAIL reset_rsp_fields got id=%0d q=%h r=%h dbz=%b to=%b want all 0",
                        bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout);
    end
    n_cmp++; if ({div_dividend, div_divisor} !== '0) begin
      n_err++; $display("FAIL reset_div_operands got %h/%h want 0/0", div_dividend, div_divisor);
    end
    tick();
    rst_n = 1'b1;
    model_ptr = 0;
    tick();
  endtask

  task automatic test_fairness();
    exp_t         exp_q[$];
    exp_t         e;
    int           order[$];
    int           g, acc, grants, resps, cycles;
    logic [N-1:0] want;
    for (int i = 0; i < N; i++) drive_req(i, $urandom, rand_divisor());
    bus.rsp_ready = 1'b1;
    grants = 0; resps = 0; cycles = 0;
    #1;
    while (resps < 5 && cycles < 800) begin
      acc = -1;
      if (bus.req_ready !== '0) begin
        g    = rr_pick(bus.req_valid, model_ptr);
        want = N'(1) << g;
        n_cmp++; if (bus.req_ready !== want) begin n_err++; $display("FAIL fair_grant got %b want %b", bus.req_ready, want); end
        exp_q.push_back(model(g, bus.req_dividend[g*W +: W], bus.req_divisor[g*W +: W]));
        order.push_back(g);
        model_ptr = (g + 1) % N;
        grants++;
        acc = g;
      end
      if (bus.rsp_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '{-1, '0, '0, 1'b0};
        n_cmp++;
        if ({bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout} !== {2'(e.id), e.q, e.r, e.dbz, 1'b0}) begin
          n_err++; $display("FAIL fair_rsp got id=%0d q=%h r=%h dbz=%b to=%b want id=%0d q=%h r=%h dbz=%b to=0",
                            bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout, e.id, e.q, e.r, e.dbz);
        end
        resps++;
      end
      tick();
      cycles++;
      if (acc >= 0) drive_req(acc, $urandom, rand_divisor());
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    n_cmp++; if (grants != 5 || resps != 5) begin n_err++; $display("FAIL fair_count got grants=%0d rsps=%0d want 5/5", grants, resps); end
    n_cmp++;
    if (order.size() != 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || order[4] != 0) begin
      n_err++; $display("FAIL fair_order got %p want 0,1,2,3,0", order);
    end
  endtask

  task automatic test_single();
    int lat;
    drive_req(0, 32'd100, 32'd7);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    model_ptr = 1;
    wait_rsp(200, lat);
    n_cmp++; if (lat != 66) begin n_err++; $display("FAIL single_latency got %0d want 66", lat); end
    n_cmp++;
    if ({bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout} !== {2'd0, 32'd14, 32'd2, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL single_rsp got id=%0d q=%0d r=%0d dbz=%b to=%b want id=0 q=14 r=2 dbz=0 to=0",
                        bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout);
    end
    consume();
  endtask

  task automatic test_dbz();
    int lat, s0;
    s0 = start_cnt;
    drive_req(2, 32'hDEADBEEF, 32'h0);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL dbz_grant got %b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    model_ptr = 3;
    wait_rsp(10, lat);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL dbz_latency got %0d want 1", lat); end
    n_cmp++;
    if ({bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout} !== {2'd2, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL dbz_rsp got id=%0d q=%h r=%h dbz=%b to=%b want id=2 q=ffffffff r=deadbeef dbz=1 to=0",
                        bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout);
    end
    consume();
    tick();
    n_cmp++; if (start_cnt != s0) begin n_err++; $display("FAIL dbz_no_start got %0d starts want 0", start_cnt - s0); end
  endtask

  task automatic test_backpressure();
    int           lat, bad;
    exp_t         e;
    logic [W-1:0] a, b;
    logic [N-1:0] want;
    a = $urandom; b = $urandom_range(1, 32'hFFFF);
    drive_req(1, a, b);
    #1;
    want = N'(1) << rr_pick(4'b0010, model_ptr);
    n_cmp++; if (bus.req_ready !== want) begin n_err++; $display("FAIL bp_grant got %b want %b", bus.req_ready, want); end
    tick();
    bus.req_valid = '0;
    model_ptr = 2;
    e = model(1, a, b);
    drive_req(3, 32'd1000, 32'd33);
    wait_rsp(200, lat);
    n_cmp++;
    if (lat != 66 || {bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout} !== {2'd1, e.q, e.r, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL bp_rsp got lat=%0d id=%0d q=%h r=%h want lat=66 id=1 q=%h r=%h", lat, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, e.q, e.r);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b1 || busy !== 1'b1 || bus.req_ready !== '0 ||
          {bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout} !== {2'd1, e.q, e.r, 1'b0, 1'b0}) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    consume();
    want = N'(1) << rr_pick(bus.req_valid, model_ptr);
    n_cmp++; if (busy !== 1'b0 || bus.req_ready !== want) begin
      n_err++; $display("FAIL bp_next_grant got busy=%b ready=%b want busy=0 ready=%b", busy, bus.req_ready, want);
    end
    tick();
    bus.req_valid = '0;
    model_ptr = 0;
    wait_rsp(200, lat);
    n_cmp++;
    if (lat != 66 || {bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder} !== {2'd3, 32'd30, 32'd10}) begin
      n_err++; $display("FAIL bp_second got lat=%0d id=%0d q=%0d r=%0d want lat=66 id=3 q=30 r=10", lat, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder);
    end
    consume();
  endtask

  task automatic test_watchdog();
    int   lat;
    exp_t e;
    hang = 1'b1;
    drive_req(0, 32'd5000, 32'd3);
    tick();
    bus.req_valid = '0;
    model_ptr = 1;
    // One LAUNCH edge, then MAX_CYCLES WAIT edges before RESP.
    wait_rsp(300, lat);
    n_cmp++; if (lat != MAXC + 1) begin n_err++; $display("FAIL wd_latency got %0d want %0d", lat, MAXC + 1); end
    n_cmp++;
    if ({bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout} !== {2'd0, 32'd0, 32'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL wd_rsp got id=%0d q=%h r=%h dbz=%b to=%b want id=0 q=0 r=0 dbz=0 to=1",
                        bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout);
    end
    consume();
    hang = 1'b0;
    drive_req(1, 32'd123456, 32'd789);
    e = model(1, 32'd123456, 32'd789);
    tick();
    bus.req_valid = '0;
    model_ptr = 2;
    wait_rsp(200, lat);
    n_cmp++;
    if (lat != 66 || {bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_timeout} !== {2'd1, e.q, e.r, 1'b0}) begin
      n_err++; $display("FAIL wd_recover got lat=%0d id=%0d q=%0d r=%0d to=%b want lat=66 id=1 q=%0d r=%0d to=0",
                        lat, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_timeout, e.q, e.r);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat, stale;
    drive_req(1, 32'h12345678, 32'd3);
    tick();
    bus.req_valid = '0;
    for (int i = 0; i < 11; i++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.rsp_valid, busy, div_start, bus.req_ready, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout} !== '0) begin
      n_err++; $display("FAIL rstmid_outputs got valid=%b busy=%b start=%b ready=%b q=%h want all 0",
                        bus.rsp_valid, busy, div_start, bus.req_ready, bus.rsp_quotient);
    end
    n_cmp++; if ({div_dividend, div_divisor} !== '0) begin n_err++; $display("FAIL rstmid_div_operands got %h/%h want 0/0", div_dividend, div_divisor); end
    tick();
    rst_n = 1'b1;
    model_ptr = 0;
    stale = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) stale++;
    end
    n_cmp++; if (stale != 0) begin n_err++; $display("FAIL rstmid_stale got %0d active cycles want 0", stale); end
    drive_req(2, 32'hFFFFFFFF, 32'h10);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL rstmid_grant got %b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    model_ptr = 3;
    wait_rsp(200, lat);
    n_cmp++;
    if (lat != 66 || {bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout} !== {2'd2, 32'h0FFFFFFF, 32'hF, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL rstmid_next got lat=%0d id=%0d q=%h r=%h want lat=66 id=2 q=0fffffff r=f", lat, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder);
    end
    consume();
  endtask

  task automatic test_random();
    int           lat, g;
    exp_t         e;
    logic [N-1:0] mask, want;
    for (int op = 0; op < 8; op++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) if (mask[i]) drive_req(i, $urandom, rand_divisor());
      #1;
      g    = rr_pick(mask, model_ptr);
      want = N'(1) << g;
      n_cmp++; if (bus.req_ready !== want) begin n_err++; $display("FAIL rand_grant op%0d got %b want %b", op, bus.req_ready, want); end
      e = model(g, bus.req_dividend[g*W +: W], bus.req_divisor[g*W +: W]);
      tick();
      bus.req_valid = '0;
      model_ptr = (g + 1) % N;
      wait_rsp(300, lat);
      n_cmp++;
      if (lat != (e.dbz ? 1 : 66) ||
          {bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout} !== {2'(e.id), e.q, e.r, e.dbz, 1'b0}) begin
        n_err++; $display("FAIL rand_rsp op%0d got lat=%0d id=%0d q=%h r=%h dbz=%b to=%b want lat=%0d id=%0d q=%h r=%h dbz=%b to=0",
                          op, lat, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout,
                          e.dbz ? 1 : 66, e.id, e.q, e.r, e.dbz);
      end
      for (int d = $urandom_range(0, 3); d > 0; d--) tick();
      consume();
    end
  endtask

  initial begin
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.rsp_ready    = 1'b0;
    test_reset();
    test_fairness();
    test_single();
    test_dbz();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no completion want finish before 500us");
    $fatal(1, "bench time limit");
  end

endmodule
